// File: rtl/vcu128_areset_gen.sv
// vcu128_areset_gen: board-level reset source for the VCU128 reset chain.
// Combines the debounced CPU_RESET pushbutton with the MMCM/PLL lock flags
// and drives a glitch-free, registered, active-high areset.
// Optional feature macro: VCU128_ARESET_CAUSE_EN adds a sticky 'cause' output
// (0 = power-on, 1 = button, 2 = loss of lock).
module vcu128_areset_gen #(
    parameter int NUM_PLL            = 2,
    parameter int SYNC_STAGES        = 2,
    parameter int DEBOUNCE_CYCLES    = 65536,
    parameter int MIN_HOLD_CYCLES    = 256,
    parameter int LOCK_STABLE_CYCLES = 1024
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               button,
    input  logic [NUM_PLL-1:0] pll_locked,
    output logic               areset,
    output logic [1:0]         state
`ifdef VCU128_ARESET_CAUSE_EN
    ,
    output logic [1:0]         cause
`endif
);

    // Counter widths: $clog2 of each limit, never narrower than one bit.
    localparam int DEB_W  = (DEBOUNCE_CYCLES    > 1) ? $clog2(DEBOUNCE_CYCLES)    : 1;
    localparam int HOLD_W = (MIN_HOLD_CYCLES    > 1) ? $clog2(MIN_HOLD_CYCLES)    : 1;
    localparam int STAB_W = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;

    localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MIN_HOLD_CYCLES - 1);
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(LOCK_STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        HOLD      = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_t;

`ifdef VCU128_ARESET_CAUSE_EN
    localparam logic [1:0] CAUSE_POR  = 2'd0;
    localparam logic [1:0] CAUSE_BTN  = 2'd1;
    localparam logic [1:0] CAUSE_LOCK = 2'd2;

    logic [1:0] cause_d, cause_q;
`endif

    logic [SYNC_STAGES-1:0]              btn_sync_d, btn_sync_q;
    logic [SYNC_STAGES-1:0][NUM_PLL-1:0] lock_sync_d, lock_sync_q;
    logic                                btn_sync_out;
    logic                                all_locked;

    logic [DEB_W-1:0]  deb_cnt_d, deb_cnt_q;
    logic              btn_db_d, btn_db_q;

    state_t            state_d, state_q;
    logic [HOLD_W-1:0] hold_cnt_d, hold_cnt_q;
    logic [STAB_W-1:0] stable_cnt_d, stable_cnt_q;
    logic              areset_d, areset_q;

    // Synchroniser shift: new sample enters stage 0, last stage is the output.
    always_comb begin
        btn_sync_d   = {btn_sync_q[SYNC_STAGES-2:0], button};
        lock_sync_d  = {lock_sync_q[SYNC_STAGES-2:0], pll_locked};
        btn_sync_out = btn_sync_q[SYNC_STAGES-1];
        all_locked   = &lock_sync_q[SYNC_STAGES-1];
    end

    // Button synchroniser presets to "pressed" and lock synchroniser to "unlocked".
    always_ff @(posedge clock) begin
        if (!resetn) begin
            btn_sync_q  <= '1;
            lock_sync_q <= '0;
        end else begin
            btn_sync_q  <= btn_sync_d;
            lock_sync_q <= lock_sync_d;
        end
    end

    // Debounce: accept a new button level only after it persists DEBOUNCE_CYCLES edges.
    always_comb begin
        deb_cnt_d = '0;
        btn_db_d  = btn_db_q;
        if (btn_sync_out != btn_db_q) begin
            if (deb_cnt_q == DEB_MAX) begin
                btn_db_d = btn_sync_out;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
    end

    // Debounce state; the debounced button starts out pressed so reset is held.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            deb_cnt_q <= '0;
            btn_db_q  <= 1'b1;
        end else begin
            deb_cnt_q <= deb_cnt_d;
            btn_db_q  <= btn_db_d;
        end
    end

    // Release sequencer next-state: button outranks lock in every state.
    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        stable_cnt_d = stable_cnt_q;
`ifdef VCU128_ARESET_CAUSE_EN
        cause_d      = cause_q;
`endif
        case (state_q)
            HOLD: begin
                if (btn_db_q) begin
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == HOLD_MAX) begin
                    state_d = WAIT_LOCK;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            WAIT_LOCK: begin
                if (btn_db_q) begin
                    state_d    = HOLD;
                    hold_cnt_d = '0;
                end else if (all_locked) begin
                    state_d      = STABLE;
                    stable_cnt_d = '0;
                end
            end
            STABLE: begin
                if (btn_db_q) begin
                    // Clearing here guarantees a full hold even if the button
                    // level flips again on the very next edge.
                    state_d    = HOLD;
                    hold_cnt_d = '0;
                end else if (!all_locked) begin
                    state_d = WAIT_LOCK;
                end else if (stable_cnt_q == STAB_MAX) begin
                    state_d = RUN;
                end else begin
                    stable_cnt_d = stable_cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (btn_db_q || !all_locked) begin
                    state_d    = HOLD;
                    hold_cnt_d = '0;
`ifdef VCU128_ARESET_CAUSE_EN
                    cause_d    = btn_db_q ? CAUSE_BTN : CAUSE_LOCK;
`endif
                end
            end
            default: begin
                state_d    = HOLD;
                hold_cnt_d = '0;
            end
        endcase
        // areset follows the next state so it moves on the same edge as RUN entry/exit.
        areset_d = (state_d != RUN);
    end

    // Sequencer registers; areset is always driven straight from this flop.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q      <= HOLD;
            hold_cnt_q   <= '0;
            stable_cnt_q <= '0;
            areset_q     <= 1'b1;
`ifdef VCU128_ARESET_CAUSE_EN
            cause_q      <= CAUSE_POR;
`endif
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            stable_cnt_q <= stable_cnt_d;
            areset_q     <= areset_d;
`ifdef VCU128_ARESET_CAUSE_EN
            cause_q      <= cause_d;
`endif
        end
    end

    assign areset = areset_q;
    assign state  = state_q;
`ifdef VCU128_ARESET_CAUSE_EN
    assign cause  = cause_q;
`endif

endmodule

// File: tb/tb_vcu128_areset_gen.sv
// tb_vcu128_areset_gen: directed bench for vcu128_areset_gen with small
// debounce/hold/stable limits. Edge numbers in comments are counted from the
// first clock edge that samples the new input value of each scenario.
module tb_vcu128_areset_gen;

    localparam int NUM_PLL = 2;

    logic               clock;
    logic               resetn;
    logic               button;
    logic [NUM_PLL-1:0] pll_locked;
    logic               areset;
    logic [1:0]         state;
`ifdef VCU128_ARESET_CAUSE_EN
    logic [1:0]         cause;
`endif

    int n_checks;
    int n_pass;

    vcu128_areset_gen #(
        .NUM_PLL            (NUM_PLL),
        .SYNC_STAGES        (2),
        .DEBOUNCE_CYCLES    (4),
        .MIN_HOLD_CYCLES    (8),
        .LOCK_STABLE_CYCLES (16)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .button     (button),
        .pll_locked (pll_locked),
        .areset     (areset),
        .state      (state)
`ifdef VCU128_ARESET_CAUSE_EN
        ,
        .cause      (cause)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance n clock edges, landing 1 time unit after the last one.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        resetn     = 1'b0;
        button     = 1'b0;
        pll_locked = 2'b11;

        // Reset state
        tick(3);
        check("rst_areset", areset, 1);
        check("rst_state", state, 0);
`ifdef VCU128_ARESET_CAUSE_EN
        check("rst_cause", cause, 0);
`endif

        // Power-on release: debounce clears at e6, hold e7..e14, stable e15..e31
        resetn = 1'b1;
        tick(14);
        check("por_e14_state", state, 1);
        tick(1);
        check("por_e15_state", state, 2);
        tick(15);
        check("por_e30_areset", areset, 1);
        check("por_e30_state", state, 2);
        tick(1);
        check("por_e31_areset", areset, 0);
        check("por_e31_state", state, 3);
`ifdef VCU128_ARESET_CAUSE_EN
        check("por_cause", cause, 0);
`endif

        // Button glitch of 3 cycles is filtered
        button = 1'b1;
        tick(3);
        button = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            check("glitch_areset", areset, 0);
        end

        // Button held 10 cycles: areset at e7, btn_db clears e16, release e41
        button = 1'b1;
        tick(6);
        check("btn_e6_areset", areset, 0);
        check("btn_e6_state", state, 3);
        tick(1);
        check("btn_e7_areset", areset, 1);
        check("btn_e7_state", state, 0);
`ifdef VCU128_ARESET_CAUSE_EN
        check("btn_cause", cause, 1);
`endif
        tick(3);
        button = 1'b0;
        tick(30);
        check("btn_e40_areset", areset, 1);
        check("btn_e40_state", state, 2);
        tick(1);
        check("btn_e41_areset", areset, 0);
        check("btn_e41_state", state, 3);

        // Lock loss for one cycle: HOLD at e3, WAIT e11, STABLE e12, RUN e28
        pll_locked = 2'b01;
        tick(1);
        pll_locked = 2'b11;
        tick(1);
        check("lock_e2_areset", areset, 0);
        tick(1);
        check("lock_e3_areset", areset, 1);
        check("lock_e3_state", state, 0);
`ifdef VCU128_ARESET_CAUSE_EN
        check("lock_cause", cause, 2);
`endif
        tick(8);
        check("lock_e11_state", state, 1);
        tick(1);
        check("lock_e12_state", state, 2);
        tick(15);
        check("lock_e27_areset", areset, 1);
        tick(1);
        check("lock_e28_areset", areset, 0);
        check("lock_e28_state", state, 3);

        // Lock bounce at stable_cnt=10: WAIT at e23, fresh STABLE e24, RUN e40
        pll_locked = 2'b01;
        tick(1);
        pll_locked = 2'b11;
        tick(11);
        check("bnc_e12_state", state, 2);
        tick(8);
        pll_locked = 2'b10;
        tick(1);
        pll_locked = 2'b11;
        tick(1);
        check("bnc_e22_state", state, 2);
        tick(1);
        check("bnc_e23_state", state, 1);
        tick(1);
        check("bnc_e24_state", state, 2);
        tick(15);
        check("bnc_e39_areset", areset, 1);
        check("bnc_e39_state", state, 2);
        tick(1);
        check("bnc_e40_areset", areset, 0);
        check("bnc_e40_state", state, 3);

        // Mid-operation reset pulse: immediate HOLD, re-release 31 edges later
        resetn = 1'b0;
        tick(1);
        check("mrst_areset", areset, 1);
        check("mrst_state", state, 0);
`ifdef VCU128_ARESET_CAUSE_EN
        check("mrst_cause", cause, 0);
`endif
        resetn = 1'b1;
        tick(30);
        check("mrst_e30_areset", areset, 1);
        tick(1);
        check("mrst_e31_areset", areset, 0);
        check("mrst_e31_state", state, 3);
`ifdef VCU128_ARESET_CAUSE_EN
        check("mrst_run_cause", cause, 0);
`endif

        // Button and lock loss seen on the same edge (e7): button wins
        button = 1'b1;
        tick(4);
        pll_locked = 2'b01;
        tick(1);
        pll_locked = 2'b11;
        tick(1);
        check("both_e6_areset", areset, 0);
        tick(1);
        check("both_e7_areset", areset, 1);
        check("both_e7_state", state, 0);
`ifdef VCU128_ARESET_CAUSE_EN
        check("both_cause", cause, 1);
`endif
        button = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
